core_exec_ctrl: RTL

Run-control sequencer for the single-cycle core. It gates instruction advance through `core_en`. A host or debug bridge drives it through a valid/ready command port with these commands: run, halt, step N, breakpoint set/clear, core reset, and status clear. It sits between the top level and the core, watches the core's PC, and counts retired instructions.

---
 rtl/core_exec_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/core_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_exec_ctrl
// Description : Run-control sequencer for a single-cycle core. Gates
//               instruction commit through core_en and accepts commands from
//               a host/debug bridge over a valid/ready port: run, halt,
//               step N, breakpoint set/clear, core reset and status clear.
//               Watches the core PC for a single hardware breakpoint and
//               counts retired instructions.
// Ports       : clk, rst (async, active-low)
//               cmd_valid/cmd_ready/cmd_op/cmd_arg : command port
//               pc                                 : core program counter
//               core_en, core_rst_n                : core control
//               state, bp_hit, retired, done_pulse : status
// Revision    : 1.0 - initial release
// ============================================================================
module core_exec_ctrl #(
    parameter int PC_W   = 8,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic [PC_W-1:0]   pc,
    output logic              core_en,
    output logic              core_rst_n,
    output logic [1:0]        state,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  retired,
    output logic              done_pulse
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_CRST = 2'b11;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_RUN        = 3'd1;
    localparam logic [2:0] OP_HALT       = 3'd2;
    localparam logic [2:0] OP_STEP       = 3'd3;
    localparam logic [2:0] OP_SET_BP     = 3'd4;
    localparam logic [2:0] OP_CLR_BP     = 3'd5;
    localparam logic [2:0] OP_RESET_CORE = 3'd6;
    localparam logic [2:0] OP_CLR_STAT   = 3'd7;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [STEP_W-1:0] r_step_cnt;
    logic              r_crst_cnt;
    logic              r_bp_en;
    logic [PC_W-1:0]   r_bp_addr;
    logic              r_skip;
    logic              r_bp_hit;
    logic [CNT_W-1:0]  r_retired;
    logic              r_done_pulse;

    logic              w_accept;
    logic              w_busy;
    logic              w_brk;
    logic              w_step_load;
    logic              w_step_dec;
    logic              w_brk_stop;
    logic              w_enter_exec;
    logic              w_enter_crst;
    logic              w_to_idle;

    assign w_accept = cmd_valid & cmd_ready;
    assign w_busy   = (r_state == S_RUN) | (r_state == S_STEP);
    // skip masks the breakpoint for the first commit after (re)entry, so a
    // resume sitting on the breakpoint PC executes that instruction.
    assign w_brk    = r_bp_en & (pc == r_bp_addr) & ~r_skip;

    assign w_enter_exec = (r_state == S_IDLE) &
                          ((w_state_nxt == S_RUN) | (w_state_nxt == S_STEP));
    assign w_enter_crst = (r_state == S_IDLE) & (w_state_nxt == S_CRST);
    assign w_to_idle    = (r_state != S_IDLE) & (w_state_nxt == S_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_step_load = 1'b0;
        w_step_dec  = 1'b0;
        w_brk_stop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_RUN: w_state_nxt = S_RUN;
                        OP_STEP: begin
                            if (cmd_arg != '0) begin
                                w_state_nxt = S_STEP;
                                w_step_load = 1'b1;
                            end
                        end
                        OP_RESET_CORE: w_state_nxt = S_CRST;
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_RUN, S_STEP: begin
                // Outside the brk case core_en is 1 in these states, so a
                // halt or final step still commits in this cycle.
                if (w_brk) begin
                    w_state_nxt = S_IDLE;
                    w_brk_stop  = 1'b1;
                end else if (w_accept && (cmd_op == OP_HALT)) begin
                    w_state_nxt = S_IDLE;
                end else if (r_state == S_STEP) begin
                    if (r_step_cnt == STEP_W'(1)) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_step_dec = 1'b1;
                    end
                end
            end
            S_CRST: begin
                // Entry loads crst_cnt=1: one cycle at 1, one at 0.
                if (!r_crst_cnt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready  = (r_state != S_CRST);
        core_en    = w_busy & ~w_brk;
        core_rst_n = rst & (r_state != S_CRST);
        state      = r_state;
    end

    assign bp_hit     = r_bp_hit;
    assign retired    = r_retired;
    assign done_pulse = r_done_pulse;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step_cnt   <= '0;
            r_crst_cnt   <= 1'b0;
            r_bp_en      <= 1'b0;
            r_bp_addr    <= '0;
            r_skip       <= 1'b0;
            r_bp_hit     <= 1'b0;
            r_retired    <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            if (w_step_load) begin
                r_step_cnt <= cmd_arg;
            end else if (w_step_dec) begin
                r_step_cnt <= r_step_cnt - STEP_W'(1);
            end

            if (w_enter_crst) begin
                r_crst_cnt <= 1'b1;
            end else if (r_state == S_CRST) begin
                r_crst_cnt <= 1'b0;
            end

            if (w_enter_exec) begin
                r_skip <= 1'b1;
            end else if (core_en || (r_state == S_CRST)) begin
                r_skip <= 1'b0;
            end

            // bp_addr/bp_en update after this cycle's brk has been evaluated
            // against the old values.
            if (w_accept && (cmd_op == OP_SET_BP)) begin
                r_bp_addr <= cmd_arg[PC_W-1:0];
                r_bp_en   <= 1'b1;
            end else if (w_accept && (cmd_op == OP_CLR_BP)) begin
                r_bp_en <= 1'b0;
            end

            // A breakpoint stop is a sticky event and is never lost to a
            // concurrent status clear.
            if (w_brk_stop) begin
                r_bp_hit <= 1'b1;
            end else if (w_accept && (cmd_op == OP_CLR_STAT)) begin
                r_bp_hit <= 1'b0;
            end

            // Clear has priority over the increment; the counter is held at
            // zero from the RESET_CORE accept through the whole CRST phase.
            if ((w_accept && (cmd_op == OP_CLR_STAT)) || w_enter_crst ||
                (r_state == S_CRST)) begin
                r_retired <= '0;
            end else if (core_en) begin
                r_retired <= r_retired + CNT_W'(1);
            end

            r_done_pulse <= w_to_idle;
        end
    end

endmodule
`default_nettype wire
